// File: rtl/board_tick_pkg.sv
// Shared types and helpers for the board tick generator: config FSM states,
// a clog2 that never returns zero, and the per-channel event slice offset.
package board_tick_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cfg_state_t;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int evt_lsb(input int ch, input int evt_width);
    return ch * evt_width;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: period register, cycle counter, wrapping
// event counter and a registered one-cycle tick pulse.
module tick_channel #(
  parameter int          CNT_WIDTH      = 32,
  parameter int          EVT_WIDTH      = 8,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 tick,
  output logic [EVT_WIDTH-1:0] evt
);

  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] cnt;

  // A load overrides a terminal count landing on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= CNT_WIDTH'(DEFAULT_PERIOD);
      cnt    <= '0;
      evt    <= '0;
      tick   <= 1'b0;
    end else if (load) begin
      period <= load_value;
      cnt    <= '0;
      tick   <= 1'b0;
    end else if (enable && (period != '0)) begin
      if (cnt == period - CNT_WIDTH'(1)) begin
        cnt  <= '0;
        tick <= 1'b1;
        evt  <= evt + EVT_WIDTH'(1);
      end else begin
        cnt  <= cnt + CNT_WIDTH'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/board_tick_gen.sv
// Board tick generator: 50% duty divided clock plus NUM_CH programmable tick
// channels whose periods are reloaded through a valid/ready config port.
module board_tick_gen
  import board_tick_pkg::*;
#(
  parameter int          CLK_DIV        = 2,
  parameter int          NUM_CH         = 4,
  parameter int          CNT_WIDTH      = 32,
  parameter int          EVT_WIDTH      = 8,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [safe_clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_WIDTH-1:0]            cfg_period,
  output logic                            clk_div_o,
  output logic [NUM_CH-1:0]               tick_o,
  output logic [NUM_CH*EVT_WIDTH-1:0]     evt_o
);

  localparam int CH_W  = safe_clog2(NUM_CH);
  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = safe_clog2(HALF);

  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
    $error("board_tick_gen: CLK_DIV must be even and >= 2");
  end
  if ((CNT_WIDTH < 64) && ((64'(DEFAULT_PERIOD) >> CNT_WIDTH) != 64'd0)) begin : g_bad_default
    $error("board_tick_gen: DEFAULT_PERIOD does not fit CNT_WIDTH");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             clk_div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      clk_div_q <= 1'b0;
    end else if (div_cnt == DIV_W'(HALF - 1)) begin
      div_cnt   <= '0;
      clk_div_q <= ~clk_div_q;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  assign clk_div_o = clk_div_q;

  cfg_state_t        state, state_nxt;
  logic              ready_q, ready_nxt;
  logic              accept;
  logic [NUM_CH-1:0] load_vec;

  // ready is registered, so it stays low on the first cycle after reset.
  assign accept    = cfg_valid & ready_q;
  assign cfg_ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range channel indices complete the handshake but match no channel.
  always_comb begin
    ready_nxt = (state_nxt == IDLE);
    load_vec  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && (cfg_ch == CH_W'(i))) load_vec[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int LSB = evt_lsb(g, EVT_WIDTH);
    tick_channel #(
      .CNT_WIDTH      (CNT_WIDTH),
      .EVT_WIDTH      (EVT_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load_vec[g]),
      .load_value (cfg_period),
      .tick       (tick_o[g]),
      .evt        (evt_o[LSB +: EVT_WIDTH])
    );
  end

endmodule
